keypad_entry: RTL
=================

Name: keypad_entry

Overview:
- Consumer end of the keypad key-event interface: takes one-cycle `key_value`/`key_valid` events and assembles a multi-digit decimal operand.
- Keeps a live BCD buffer for the display path.
- On ENTER (0xA), serially converts the buffer to binary and pulses `num_valid` with the committed value.
- Sits between the keypad reader and the application datapath or FSM.

Parameters:
- MAX_DIGITS, 3: maximum digits held in the entry buffer (≥1).
- BIN_W, 10: width of `num_bin`; must satisfy 2^BIN_W > 10^MAX_DIGITS − 1.
- TIMEOUT_CYCLES, 50000000: inactivity limit in clk cycles; used only when ENTRY_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_value  in  4  key code; 0–9 digit, A ENTER, B backspace, C clear, D/E/F unused.
- key_valid  in  1  key event; every cycle it is high counts as one event.
- entry_bcd  out  4*MAX_DIGITS  live buffer; least-significant digit in [3:0]; unused upper nibbles are 0.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently held.
- num_bin  out  BIN_W  last committed value; held until the next commit.
- num_valid  out  1  one-cycle pulse when `num_bin` updates.
- busy  out  1  high during CONVERT and DONE; key events are dropped.
- err_overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - entry_bcd = 0, digit_count = 0, num_bin = 0.
  - num_valid = 0, busy = 0, err_overflow = 0.
  - Internal accumulator and step index = 0.
- Reset mid-conversion aborts it; num_bin returns to 0.
- States: IDLE (buffer empty), ENTRY, CONVERT, DONE. All key handling happens on the rising edge where key_valid = 1.
- IDLE:
  - Digit d: entry_bcd ← d, count ← 1, go to ENTRY. A leading 0 is accepted and counted.
  - A, B, C, D, E, F: ignored; no outputs change.
- ENTRY:
  - Digit d with count < MAX_DIGITS: entry_bcd ← (entry_bcd << 4) | d, count+1.
  - Digit d with count == MAX_DIGITS: buffer unchanged; err_overflow = 1 for the next cycle.
  - B: entry_bcd ← entry_bcd >> 4, count−1. If count reaches 0, go to IDLE.
  - C: entry_bcd ← 0, count ← 0, go to IDLE.
  - A: acc ← 0, step ← 0, go to CONVERT.
  - D, E, F: ignored.
- CONVERT:
  - Runs exactly MAX_DIGITS cycles.
  - Each cycle: acc ← acc*10 + nibble[MAX_DIGITS−1−step], step+1. Upper zero nibbles contribute 0.
  - The multiply is computed as (acc<<3)+(acc<<1), BIN_W bits wide; no overflow is possible given the BIN_W constraint.
  - After the last step, go to DONE.
- DONE (one cycle):
  - num_bin ← acc, num_valid = 1.
  - entry_bcd ← 0, count ← 0.
  - Next state is IDLE.
- Latency: with ENTER sampled at edge E0, num_valid is high for the cycle after edge E0 + MAX_DIGITS + 1. For MAX_DIGITS = 3 that is 4 edges.
- busy is high throughout CONVERT and DONE. Any key_valid in those states is discarded with no effect and no error.
- num_valid and err_overflow are registered pulses, never high for 2 consecutive cycles from a single event.
- entry_bcd stays stable during CONVERT, showing the committed digits, and clears in DONE.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- Defined:
  - A counter runs while in ENTRY and resets to 0 on every accepted or ignored key event.
  - When it reaches TIMEOUT_CYCLES−1 with no event, the buffer clears and the block returns to IDLE, exactly as key C does.
  - The counter is held at 0 in all other states.
  - No output pulse is generated on timeout.
- Not defined: no counter is built; a partial entry persists indefinitely.

Test Plan:
- Reset, then keys 4, 2, 7, A (each key_valid 1 cycle, gaps ≥1) → entry_bcd = 0x427, digit_count = 3; busy high for 4 cycles; num_bin = 427, num_valid exactly 1 cycle, 4 edges after ENTER; buffer then returns to 0.
- Keys 9, 9, 9, 5 → 4th digit rejected, err_overflow one pulse, entry_bcd stays 0x999; then A → num_bin = 999.
- Keys 1, 2, B, 3, A → entry_bcd 0x12 → 0x1 → 0x13; num_bin = 13.
- Key A in IDLE, key B in IDLE, then 5, C, A → no num_valid at any point; digit_count returns to 0 after C; num_bin keeps its previous value.
- Keys 8, A, then key 3 during busy, then rst_n low mid-CONVERT on a second run → key 3 ignored and num_bin = 8; after reset all outputs are 0 and no num_valid occurs.
- ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES = 20: key 6, idle 25 cycles → buffer cleared at cycle 20; then 6 followed by key 7 at cycle 15 → no clear, entry_bcd = 0x67.

Source files
------------

// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - key-event and operand bundle between keypad reader, entry block and application
interface keypad_entry_if #(
  parameter int MAX_DIGITS = 3,
  parameter int BIN_W      = 10
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [3:0]              key_value;
  logic                    key_valid;
  logic [4*MAX_DIGITS-1:0] entry_bcd;
  logic [CW-1:0]           digit_count;
  logic [BIN_W-1:0]        num_bin;
  logic                    num_valid;
  logic                    busy;
  logic                    err_overflow;

  // Keypad/application side: issues key events, consumes buffer and operand.
  modport master (
    output key_value, key_valid,
    input  entry_bcd, digit_count, num_bin, num_valid, busy, err_overflow
  );

  // Entry block side.
  modport slave (
    input  key_value, key_valid,
    output entry_bcd, digit_count, num_bin, num_valid, busy, err_overflow
  );
endinterface

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - decimal keypad entry buffer with serial BCD-to-binary commit (optional ENTRY_TIMEOUT_EN)
module keypad_entry #(
  parameter int MAX_DIGITS     = 3,
  parameter int BIN_W          = 10
`ifdef ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input logic           clk,
  input logic           rst_n,
  keypad_entry_if.slave kp
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int DW = 4 * MAX_DIGITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTRY   = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [3:0] K_ENTER = 4'hA;
  localparam logic [3:0] K_BACK  = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hC;

  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] STEP_LAST = CW'(MAX_DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    step_q, step_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [BIN_W-1:0] num_q, num_d;
  logic             num_valid_q, num_valid_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       nib;
  logic             is_digit;
  logic             timeout;

  assign is_digit = (kp.key_value <= 4'd9);

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  // Inactivity counter: only advances in ENTRY while no key event arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != S_ENTRY || kp.key_valid || timeout) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == S_ENTRY) && !kp.key_valid &&
                   (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Conversion walks the buffer from the most-significant nibble downward.
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (int'(step_q) == MAX_DIGITS - 1 - i) nib = bcd_q[4*i +: 4];
    end
  end

  // Entry FSM and conversion datapath next-state.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    count_d     = count_q;
    step_d      = step_q;
    acc_d       = acc_q;
    num_d       = num_q;
    num_valid_d = 1'b0;
    ovf_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kp.key_valid && is_digit) begin
          bcd_d   = DW'(kp.key_value);
          count_d = CW'(1);
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (timeout) begin
          bcd_d   = '0;
          count_d = '0;
          state_d = S_IDLE;
        end else if (kp.key_valid) begin
          if (is_digit) begin
            if (count_q < CNT_MAX) begin
              bcd_d   = (bcd_q << 4) | DW'(kp.key_value);
              count_d = count_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (kp.key_value == K_BACK) begin
            bcd_d   = bcd_q >> 4;
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = S_IDLE;
          end else if (kp.key_value == K_CLEAR) begin
            bcd_d   = '0;
            count_d = '0;
            state_d = S_IDLE;
          end else if (kp.key_value == K_ENTER) begin
            acc_d   = '0;
            step_d  = '0;
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        // acc*10 as shifts; BIN_W is sized so this cannot wrap.
        acc_d  = (acc_q << 3) + (acc_q << 1) + BIN_W'(nib);
        step_d = step_q + 1'b1;
        if (step_q == STEP_LAST) state_d = S_DONE;
      end
      default: begin
        num_d       = acc_q;
        num_valid_d = 1'b1;
        bcd_d       = '0;
        count_d     = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      count_q     <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign kp.entry_bcd    = bcd_q;
  assign kp.digit_count  = count_q;
  assign kp.num_bin      = num_q;
  assign kp.num_valid    = num_valid_q;
  assign kp.err_overflow = ovf_q;
  assign kp.busy         = (state_q == S_CONVERT) || (state_q == S_DONE);
endmodule
